// File: rtl/clock_pkg.sv
// Shared state encoding, field widths and default terminal values for the clock
// timekeeping controller.
package clock_pkg;

    typedef enum logic [1:0] {
        Run    = 2'd0,
        SetHr  = 2'd1,
        SetMin = 2'd2
    } state_e;

    localparam int unsigned HR_W  = 6;
    localparam int unsigned MIN_W = 6;
    localparam int unsigned SEC_W = 6;

    localparam int unsigned HR_MAX_DEF  = 23;
    localparam int unsigned MIN_MAX_DEF = 59;
    localparam int unsigned SEC_MAX_DEF = 59;

    // The mode button walks the states in a fixed ring.
    function automatic state_e next_mode_state(input state_e cur);
        state_e nxt;
        case (cur)
            Run:     nxt = SetHr;
            SetHr:   nxt = SetMin;
            default: nxt = Run;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo counter with synchronous clear; wraps to zero once count reaches or
// exceeds MAX, so an out-of-range value self-corrects on its next advance.
module mod_counter
    import clock_pkg::*;
#(
    parameter int unsigned WIDTH = SEC_W,
    parameter int unsigned MAX   = SEC_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_max;

    assign at_max = (count_q >= MaxVal);

    // Clear beats enable; the carry out still reflects the enable.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = at_max ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign wrap  = en && at_max;

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping and time-set controller: owns hr/min/sec, sequences roll-over and
// runs the two-button set-mode state machine.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned HR_MAX  = HR_MAX_DEF,
    parameter int unsigned MIN_MAX = MIN_MAX_DEF,
    parameter int unsigned SEC_MAX = SEC_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick_1hz,
    input  logic            btn_mode,
    input  logic            btn_inc,
    output logic [0:HR_W-1]  hr,
    output logic [0:MIN_W-1] min,
    output logic [0:SEC_W-1] sec,
    output logic            set_hr,
    output logic            set_min,
    output logic            blink,
    output logic            day_pulse
);

    state_e state_q;
    state_e state_d;

    logic in_run;
    logic in_set_hr;
    logic in_set_min;
    logic inc_ok;

    logic sec_en;
    logic sec_clr;
    logic sec_wrap;
    logic min_en;
    logic min_wrap;
    logic hr_en;
    logic hr_wrap;

    logic [SEC_W-1:0] sec_cnt;
    logic [MIN_W-1:0] min_cnt;
    logic [HR_W-1:0]  hr_cnt;

    logic blink_q;
    logic blink_d;
    logic day_pulse_q;
    logic day_pulse_d;
    logic set_hr_q;
    logic set_hr_d;
    logic set_min_q;
    logic set_min_d;

    assign in_run     = (state_q == Run);
    assign in_set_hr  = (state_q == SetHr);
    assign in_set_min = (state_q == SetMin);

    // Mode wins over a coincident increment.
    assign inc_ok = btn_inc && !btn_mode;

    // A tick coincident with mode in RUN still carries; the sec clear on entry
    // into SET_HR then overrides the sec update.
    assign sec_en  = in_run && tick_1hz;
    assign sec_clr = in_run && btn_mode;
    assign min_en  = (in_run && sec_wrap) || (in_set_min && inc_ok);
    assign hr_en   = (in_run && min_wrap) || (in_set_hr && inc_ok);

    mod_counter #(
        .WIDTH (SEC_W),
        .MAX   (SEC_MAX)
    ) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sec_clr),
        .en    (sec_en),
        .count (sec_cnt),
        .wrap  (sec_wrap)
    );

    mod_counter #(
        .WIDTH (MIN_W),
        .MAX   (MIN_MAX)
    ) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (min_en),
        .count (min_cnt),
        .wrap  (min_wrap)
    );

    mod_counter #(
        .WIDTH (HR_W),
        .MAX   (HR_MAX)
    ) u_hr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (hr_en),
        .count (hr_cnt),
        .wrap  (hr_wrap)
    );

    always_comb begin
        state_d     = state_q;
        blink_d     = blink_q;
        day_pulse_d = in_run && hr_wrap;

        if (btn_mode) begin
            state_d = next_mode_state(state_q);
        end

        // Blink runs only while parked in a SET state; any transition resets it.
        if (state_d == Run || state_d != state_q) begin
            blink_d = 1'b0;
        end else if (tick_1hz) begin
            blink_d = ~blink_q;
        end

        set_hr_d  = (state_d == SetHr);
        set_min_d = (state_d == SetMin);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= Run;
            blink_q     <= 1'b0;
            day_pulse_q <= 1'b0;
            set_hr_q    <= 1'b0;
            set_min_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            blink_q     <= blink_d;
            day_pulse_q <= day_pulse_d;
            set_hr_q    <= set_hr_d;
            set_min_q   <= set_min_d;
        end
    end

    assign hr        = hr_cnt;
    assign min       = min_cnt;
    assign sec       = sec_cnt;
    assign set_hr    = set_hr_q;
    assign set_min   = set_min_q;
    assign blink     = blink_q;
    assign day_pulse = day_pulse_q;

    a_one_set_field: assert property (@(posedge clk) disable iff (!rst_n)
        !(set_hr && set_min));

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then a
// randomized stress run compared each cycle against a behavioural clock model.
module tb_clock_time_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic [0:5] hr;
    logic [0:5] min;
    logic [0:5] sec;
    logic       set_hr;
    logic       set_min;
    logic       blink;
    logic       day_pulse;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    clock_time_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1hz  (tick_1hz),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .hr        (hr),
        .min       (min),
        .sec       (sec),
        .set_hr    (set_hr),
        .set_min   (set_min),
        .blink     (blink),
        .day_pulse (day_pulse)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = running, 1 = setting hours, 2 = setting minutes.
    int m_mode = 0;
    int m_hr   = 0;
    int m_min  = 0;
    int m_sec  = 0;
    int m_blink = 0;
    int m_day  = 0;
    bit started = 1'b0;

    task automatic model_step(input bit rst, input bit mode, input bit inc, input bit tick);
        m_day = 0;
        if (!rst) begin
            m_mode = 0; m_hr = 0; m_min = 0; m_sec = 0; m_blink = 0;
        end else if (m_mode == 0) begin
            if (tick) begin
                if (m_sec >= 59) begin
                    m_sec = 0;
                    if (m_min >= 59) begin
                        m_min = 0;
                        if (m_hr >= 23) begin
                            m_hr = 0;
                            m_day = 1;
                        end else begin
                            m_hr = m_hr + 1;
                        end
                    end else begin
                        m_min = m_min + 1;
                    end
                end else begin
                    m_sec = m_sec + 1;
                end
            end
            if (mode) begin
                m_mode = 1;
                m_sec = 0;
            end
            m_blink = 0;
        end else if (mode) begin
            m_mode = (m_mode == 1) ? 2 : 0;
            m_blink = 0;
        end else begin
            if (inc) begin
                if (m_mode == 1) m_hr = (m_hr >= 23) ? 0 : m_hr + 1;
                else m_min = (m_min >= 59) ? 0 : m_min + 1;
            end
            if (tick) m_blink = 1 - m_blink;
        end
    endtask

    // Compare process: advance the model on each edge, check the DUT just after.
    always @(posedge clk) begin
        if (!rst_n) started = 1'b1;
        if (started) begin
            model_step(rst_n, btn_mode, btn_inc, tick_1hz);
            #1;
            check("model_hr", int'(hr), m_hr);
            check("model_min", int'(min), m_min);
            check("model_sec", int'(sec), m_sec);
            check("model_set_hr", int'(set_hr), (m_mode == 1) ? 1 : 0);
            check("model_set_min", int'(set_min), (m_mode == 2) ? 1 : 0);
            check("model_blink", int'(blink), m_blink);
            check("model_day_pulse", int'(day_pulse), m_day);
            check("range_ok", int'(hr <= 23 && min <= 59 && sec <= 59), 1);
            check("one_set_field", int'(set_hr && set_min), 0);
        end
    end

    task automatic step(input bit mode, input bit inc, input bit tick);
        @(negedge clk);
        btn_mode = mode;
        btn_inc  = inc;
        tick_1hz = tick;
        @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        tick_1hz = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_time(input string name, input int h, input int m, input int s);
        check({name, "_hr"}, int'(hr), h);
        check({name, "_min"}, int'(min), m);
        check({name, "_sec"}, int'(sec), s);
    endtask

    task automatic check_all_zero(input string name);
        check_time(name, 0, 0, 0);
        check({name, "_set_hr"}, int'(set_hr), 0);
        check({name, "_set_min"}, int'(set_min), 0);
        check({name, "_blink"}, int'(blink), 0);
        check({name, "_day_pulse"}, int'(day_pulse), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        tick_1hz = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        do_reset();
        check_all_zero("reset");

        repeat (61) step(1'b0, 1'b0, 1'b1);
        check_time("t61", 0, 1, 1);

        // Reset from SET_MIN with a non-zero count.
        repeat (3) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("enter_set_min", int'(set_min), 1);
        do_reset();
        check_all_zero("mid_reset");

        // Preload 23:59:58 and roll the day over.
        step(1'b1, 1'b0, 1'b0);
        check("preload_set_hr", int'(set_hr), 1);
        repeat (23) step(1'b0, 1'b1, 1'b0);
        check("preload_hr23", int'(hr), 23);
        step(1'b1, 1'b0, 1'b0);
        repeat (59) step(1'b0, 1'b1, 1'b0);
        check_time("preload_set", 23, 59, 0);
        step(1'b1, 1'b0, 1'b0);
        check("preload_run", int'(set_hr || set_min), 0);
        repeat (58) step(1'b0, 1'b0, 1'b1);
        check_time("t58", 23, 59, 58);
        step(1'b0, 1'b0, 1'b1);
        check_time("t59", 23, 59, 59);
        check("t59_day", int'(day_pulse), 0);
        step(1'b0, 1'b0, 1'b1);
        check_time("rollover", 0, 0, 0);
        check("rollover_day", int'(day_pulse), 1);
        step(1'b0, 1'b0, 1'b0);
        check("day_pulse_drop", int'(day_pulse), 0);

        // Hour set: wrap past 23, ticks only toggle blink.
        do_reset();
        repeat (5) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check("sethr_sec_clear", int'(sec), 0);
        check("sethr_blink0", int'(blink), 0);
        repeat (25) step(1'b0, 1'b1, 1'b0);
        check_time("sethr_wrap", 1, 0, 0);
        step(1'b0, 1'b0, 1'b1);
        check("blink_t1", int'(blink), 1);
        step(1'b0, 1'b0, 1'b1);
        check("blink_t2", int'(blink), 0);
        step(1'b0, 1'b0, 1'b1);
        check("blink_t3", int'(blink), 1);
        check("sethr_sec_held", int'(sec), 0);
        step(1'b0, 1'b1, 1'b1);
        check_time("inc_tick", 2, 0, 0);
        check("inc_tick_blink", int'(blink), 0);

        // Minute set: wrap past 59 with no hour carry.
        step(1'b1, 1'b0, 1'b0);
        check("setmin_flag", int'(set_min), 1);
        check("setmin_blink0", int'(blink), 0);
        repeat (61) step(1'b0, 1'b1, 1'b0);
        check_time("setmin_wrap", 2, 1, 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_time("resume", 2, 1, 1);

        // Mode beats a coincident increment.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("mode_inc_set_min", int'(set_min), 1);
        check("mode_inc_hr", int'(hr), 2);
        step(1'b1, 1'b0, 1'b0);

        // Mode with tick in RUN at 10:59:59.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (59) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (59) step(1'b0, 1'b0, 1'b1);
        check_time("pre_mode_tick", 10, 59, 59);
        step(1'b1, 1'b0, 1'b1);
        check_time("mode_tick", 11, 0, 0);
        check("mode_tick_set_hr", int'(set_hr), 1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("setmin_blink1", int'(blink), 1);
        step(1'b1, 1'b0, 1'b1);
        check_time("exit_tick_dropped", 11, 0, 0);
        check("exit_run", int'(set_min), 0);
        check("exit_blink", int'(blink), 0);

        // Randomized stress against the model.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 999) < 2) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 30,
                     $urandom_range(0, 99) < 40);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
